// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector sampled on a divided tick.
// Define SEQDET_SYNC_EN to pass x through a 2-flop synchroniser.
module seq_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int DIV     = 20000000,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               tick,
  output logic               match,
  output logic               match_hold,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   progress,
  output logic               cfg_err,
  output logic [6:0]         seg
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);

  logic               x_s;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   hcnt_q, hcnt_d;
  logic               match_q, match_d;
  logic               hold_q, hold_d;
  logic [CNT_W-1:0]   mcnt_q, mcnt_d;
  logic [LEN_W-1:0]   prog_q, prog_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] nh;
  logic [LEN_W-1:0]   nc;
  logic               legal;
  logic               hit;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] pre;
  logic [LEN_W-1:0]   best;

`ifdef SEQDET_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], x};
  end

  assign x_s = sync_q[1];
`else
  assign x_s = x;
`endif

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == LAST);
    hist_d  = hist_q;
    hcnt_d  = hcnt_q;
    match_d = 1'b0;
    hold_d  = hold_q;
    mcnt_d  = mcnt_q;
    prog_d  = prog_q;
    err_d   = err_q;

    nh    = {hist_q[MAX_LEN-2:0], x_s};
    nc    = (hcnt_q >= LMAX) ? LMAX : hcnt_q + 1'b1;
    legal = (pat_len != '0) && (pat_len <= LMAX);
    mask  = MAX_LEN'((1 << pat_len) - 1);
    hit   = legal && (nc >= pat_len) &&
            (((nh ^ pattern) & mask) == '0);

    // Longest pattern prefix that ends on the newest bit.
    best = '0;
    pre  = '0;
    for (int k = 1; k < MAX_LEN; k++) begin
      mask = MAX_LEN'((1 << k) - 1);
      pre  = pattern >> (pat_len - LEN_W'(k));
      if ((LEN_W'(k) < pat_len) && (LEN_W'(k) <= nc) &&
          (((nh ^ pre) & mask) == '0))
        best = LEN_W'(k);
    end

    if (tick_q) begin
      hist_d = nh;
      err_d  = !legal;
      if (!legal) begin
        prog_d = '0;
        hold_d = 1'b0;
        hcnt_d = nc;
      end else if (hit) begin
        match_d = 1'b1;
        hold_d  = 1'b1;
        prog_d  = pat_len;
        hcnt_d  = overlap ? nc : '0;
        if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
      end else begin
        hold_d = 1'b0;
        prog_d = best;
        hcnt_d = nc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      match_q <= 1'b0;
      hold_q  <= 1'b0;
      mcnt_q  <= '0;
      prog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      hist_q  <= hist_d;
      hcnt_q  <= hcnt_d;
      match_q <= match_d;
      hold_q  <= hold_d;
      mcnt_q  <= mcnt_d;
      prog_q  <= prog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    case (prog_q)
      LEN_W'(0): seg = 7'b0000001;
      LEN_W'(1): seg = 7'b1001111;
      LEN_W'(2): seg = 7'b0010010;
      LEN_W'(3): seg = 7'b0000110;
      LEN_W'(4): seg = 7'b1001100;
      LEN_W'(5): seg = 7'b0100100;
      LEN_W'(6): seg = 7'b0100000;
      LEN_W'(7): seg = 7'b0001111;
      LEN_W'(8): seg = 7'b0000000;
      LEN_W'(9): seg = 7'b0000100;
      default:   seg = 7'b1111110;
    endcase
  end

  assign tick       = tick_q;
  assign match      = match_q;
  assign match_hold = hold_q;
  assign match_cnt  = mcnt_q;
  assign progress   = prog_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector with DIV=4.
// A second instance with CNT_W=2 covers counter saturation.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x = 1'b0;
  logic [7:0] pattern = 8'b0110;
  logic [3:0] pat_len = 4'd4;
  logic       overlap = 1'b0;

  logic       tick, match, match_hold, cfg_err;
  logic [7:0] match_cnt;
  logic [3:0] progress;
  logic [6:0] seg;

  logic       tick2, match2, hold2, err2;
  logic [1:0] cnt2;
  logic [3:0] prog2;
  logic [6:0] seg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN(8), .LEN_W(4), .DIV(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .x(x),
    .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .tick(tick),
    .match(match), .match_hold(match_hold),
    .match_cnt(match_cnt), .progress(progress),
    .cfg_err(cfg_err), .seg(seg)
  );

  seq_pattern_detector #(
    .MAX_LEN(8), .LEN_W(4), .DIV(4), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .x(x),
    .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .tick(tick2),
    .match(match2), .match_hold(hold2),
    .match_cnt(cnt2), .progress(prog2),
    .cfg_err(err2), .seg(seg2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Waits for the tick cycle, then returns just after its edge.
  task automatic step(input logic xb);
    bit seen;
    seen = 1'b0;
    x = xb;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clk);
      if (tick === 1'b1) seen = 1'b1;
    end
    chk("tick_wait", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic stp(input logic xb, input logic em,
                     input logic [3:0] ep, input string tag);
    step(xb);
    chk({tag, "_match"}, 32'(match), 32'(em));
    chk({tag, "_prog"}, 32'(progress), 32'(ep));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_hold", 32'(match_hold), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_prog", 32'(progress), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_seg", 32'(seg), 32'b0000001);
    @(negedge clk);
    rst = 1'b0;

    // 0110, non-overlapping
    stp(1'b0, 1'b0, 4'd1, "b1_t1");
    stp(1'b1, 1'b0, 4'd2, "b1_t2");
    stp(1'b1, 1'b0, 4'd3, "b1_t3");
    chk("b1_seg3", 32'(seg), 32'b0000110);
    stp(1'b0, 1'b1, 4'd4, "b1_t4");
    chk("b1_seg4", 32'(seg), 32'b1001100);
    chk("b1_cnt", 32'(match_cnt), 32'd1);
    chk("b1_hold", 32'(match_hold), 32'd1);
    @(posedge clk);
    #1;
    chk("b1_pulse", 32'(match), 32'd0);
    chk("b1_hold2", 32'(match_hold), 32'd1);
    chk("b1_prog2", 32'(progress), 32'd4);

    // 0110110 overlapping
    do_reset();
    overlap = 1'b1;
    stp(1'b0, 1'b0, 4'd1, "b2_t1");
    stp(1'b1, 1'b0, 4'd2, "b2_t2");
    stp(1'b1, 1'b0, 4'd3, "b2_t3");
    stp(1'b0, 1'b1, 4'd4, "b2_t4");
    stp(1'b1, 1'b0, 4'd2, "b2_t5");
    chk("b2_hold5", 32'(match_hold), 32'd0);
    stp(1'b1, 1'b0, 4'd3, "b2_t6");
    stp(1'b0, 1'b1, 4'd4, "b2_t7");
    chk("b2_cnt", 32'(match_cnt), 32'd2);

    // 0110110 non-overlapping: bits after a match are not reused
    do_reset();
    overlap = 1'b0;
    stp(1'b0, 1'b0, 4'd1, "b3_t1");
    stp(1'b1, 1'b0, 4'd2, "b3_t2");
    stp(1'b1, 1'b0, 4'd3, "b3_t3");
    stp(1'b0, 1'b1, 4'd4, "b3_t4");
    stp(1'b1, 1'b0, 4'd0, "b3_t5");
    stp(1'b1, 1'b0, 4'd0, "b3_t6");
    stp(1'b0, 1'b0, 4'd1, "b3_t7");
    chk("b3_cnt", 32'(match_cnt), 32'd1);

    // 111, x held high
    do_reset();
    pattern = 8'b111;
    pat_len = 4'd3;
    stp(1'b1, 1'b0, 4'd1, "b4_t1");
    stp(1'b1, 1'b0, 4'd2, "b4_t2");
    stp(1'b1, 1'b1, 4'd3, "b4_t3");
    stp(1'b1, 1'b0, 4'd1, "b4_t4");
    stp(1'b1, 1'b0, 4'd2, "b4_t5");
    stp(1'b1, 1'b1, 4'd3, "b4_t6");
    chk("b4_cnt", 32'(match_cnt), 32'd2);

    do_reset();
    overlap = 1'b1;
    stp(1'b1, 1'b0, 4'd1, "b5_t1");
    stp(1'b1, 1'b0, 4'd2, "b5_t2");
    stp(1'b1, 1'b1, 4'd3, "b5_t3");
    stp(1'b1, 1'b1, 4'd3, "b5_t4");
    stp(1'b1, 1'b1, 4'd3, "b5_t5");
    stp(1'b1, 1'b1, 4'd3, "b5_t6");
    chk("b5_cnt", 32'(match_cnt), 32'd4);

    // illegal lengths: history keeps shifting
    do_reset();
    overlap = 1'b0;
    pattern = 8'b0110;
    pat_len = 4'd0;
    stp(1'b0, 1'b0, 4'd0, "b6_t1");
    chk("b6_err1", 32'(cfg_err), 32'd1);
    chk("b6_seg1", 32'(seg), 32'b0000001);
    stp(1'b1, 1'b0, 4'd0, "b6_t2");
    pat_len = 4'd9;
    stp(1'b1, 1'b0, 4'd0, "b6_t3");
    chk("b6_err3", 32'(cfg_err), 32'd1);
    stp(1'b0, 1'b0, 4'd0, "b6_t4");
    chk("b6_err4", 32'(cfg_err), 32'd1);
    chk("b6_hold", 32'(match_hold), 32'd0);
    chk("b6_cnt", 32'(match_cnt), 32'd0);
    chk("b6_seg4", 32'(seg), 32'b0000001);
    pat_len = 4'd4;
    stp(1'b1, 1'b0, 4'd2, "b6_t5");
    chk("b6_err5", 32'(cfg_err), 32'd0);
    chk("b6_seg5", 32'(seg), 32'b0010010);

    // 2-bit counter saturation
    do_reset();
    pattern = 8'b1;
    pat_len = 4'd1;
    step(1'b1);
    chk("b7_c1", 32'(cnt2), 32'd1);
    chk("b7_m1", 32'(match2), 32'd1);
    step(1'b1);
    chk("b7_c2", 32'(cnt2), 32'd2);
    step(1'b1);
    chk("b7_c3", 32'(cnt2), 32'd3);
    step(1'b1);
    chk("b7_c4", 32'(cnt2), 32'd3);
    chk("b7_m4", 32'(match2), 32'd1);
    step(1'b1);
    chk("b7_c5", 32'(cnt2), 32'd3);
    chk("b7_wide", 32'(match_cnt), 32'd5);

    // asynchronous reset after a partial match
    do_reset();
    pattern = 8'b0110;
    pat_len = 4'd4;
    stp(1'b0, 1'b0, 4'd1, "b8_t1");
    stp(1'b1, 1'b0, 4'd2, "b8_t2");
    #2;
    rst = 1'b1;
    #1;
    chk("b8_prog", 32'(progress), 32'd0);
    chk("b8_seg", 32'(seg), 32'b0000001);
    chk("b8_tick", 32'(tick), 32'd0);
    chk("b8_hold", 32'(match_hold), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b8_tick_c%0d", i), 32'(tick),
          (i == 4) ? 32'd1 : 32'd0);
    end
    stp(1'b1, 1'b0, 4'd0, "b8_t3");
    stp(1'b0, 1'b0, 4'd1, "b8_t4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
